pll_measure_sequencer: RTL and testbench
========================================

Name: pll_measure_sequencer

Overview:
Avalon-MM master that sequences one PLL clock-measurement slave through complete measurement runs. Each run:
- optionally pulses pll_reset and waits for lock;
- loads the window, clears, starts and polls the counters until done;
- streams out the seven result registers.
It repeats for num_runs runs. Sits between the HPS/host control registers and the measurement slave, on the same avalon_clock.

Parameters:
SETTLE_CYCLES, 8, cycles clear is held before go, so slow PLL domains see clear.
RST_HOLD_CYCLES, 16, cycles pll_reset is held high.
LOCK_TIMEOUT, 1000000, cycles to wait for locked==1 before error.
POLL_GAP, 4, idle cycles between consecutive go polls.

Ports:
avalon_clock  in  1  clock
p_reset_1  in  1  reset, asynchronous, active-high; clock avalon_clock
start  in  1  one-cycle pulse; begins a sequence when idle
window_len  in  32  ref-clock window, written to slave count_num
num_runs  in  8  runs per sequence
do_pll_reset  in  1  pulse PLL reset before each run
m_address  out  4  slave word address
m_write  out  1  slave write strobe
m_read  out  1  slave read strobe
m_writedata  out  32  slave write data
m_readdata  in  32  slave read data, valid the cycle after m_read
locked  in  1  PLL lock (synchronised internally, 2 flops)
res_valid  out  1  one-cycle result strobe
res_run  out  8  run index of result
res_index  out  3  0..6 = ref,c0,c1,c2,pr0,pr1,p01
res_data  out  32  result value
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
error  out  1  sticky lock-timeout flag; cleared on next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; run and index counters 0.
- Strobes: at most one of m_write/m_read per cycle, each one cycle wide. m_address and m_writedata are valid in the same cycle as the strobe.
- Slave register map: 0 go, 1 count_num, 2 clear, 3..9 results, 11 pll_reset.
- IDLE:
  - start accepted only here; latch window_len, num_runs and do_pll_reset; clear error; busy=1.
  - num_runs==0: pulse done next cycle, return to IDLE, no bus traffic.
  - start while busy is ignored.
- PRST_ON: write addr 11 data 1; hold RST_HOLD_CYCLES.
- PRST_OFF: write addr 11 data 0.
- WAIT_LOCK: count cycles until synchronised locked==1.
  - Timeout at LOCK_TIMEOUT: set error, pulse done, go IDLE. Remaining runs are abandoned.
  - Entered only when do_pll_reset is latched; otherwise LOAD follows IDLE or NEXT directly.
- LOAD: write addr 1 = latched window_len.
- CLEAR: write addr 2; wait SETTLE_CYCLES.
- GO: write addr 0 data 1.
- POLL:
  - Wait POLL_GAP cycles, then read addr 0, then wait 1 cycle.
  - m_readdata[0]==1: repeat POLL.
  - m_readdata[0]==0: go to READ.
  - The first poll is never issued before POLL_GAP cycles after GO, because go updates one cycle late.
- READ:
  - For index 0..6: read addr 3+index. Next cycle, drive res_valid=1 with res_data=m_readdata, res_index=index, res_run=current run.
  - One read every 2 cycles, so READ takes 14 cycles.
- NEXT:
  - Run counter +1. If it equals num_runs: pulse done, busy=0, go IDLE.
  - Else go to PRST_ON or LOAD.
- window_len of 0 or 1: the slave finishes immediately. The sequencer still polls once and reads results normally; no special case.
- Counter widths:
  - Internal cycle counter 20 bits min; ceil(log2(max parameter+1)).
  - Run counter 8 bits, no wrap since it stops at num_runs (max 255).
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. The slave's go bit is not cleared by this block; the next sequence's CLEAR/GO re-initialises it.

Decomposition:
- Package pll_meas_pkg:
  - address constants ADDR_GO=0, ADDR_COUNT=1, ADDR_CLEAR=2, ADDR_RES_BASE=3, ADDR_LOCKED=10, ADDR_PRST=11;
  - NUM_RESULTS=7;
  - state enum (IDLE, PRST_ON, PRST_OFF, WAIT_LOCK, LOAD, CLEAR, GO, POLL, READ, NEXT).
- One sub-module, pll_seq_timer: a loadable down-counter with zero flag, shared for the hold, settle, gap and timeout waits.

Test Plan:
- start, num_runs=1, window_len=100, do_pll_reset=0, slave model go=1 for 120 cycles -> bus writes (1,100),(2,x),(0,1); polls until go=0; 7 res_valid with res_index 0..6 and slave values; one done; error=0.
- num_runs=3, do_pll_reset=1, locked rises 50 cycles after PRST_OFF -> each run shows writes (11,1), held 16 cycles, then (11,0); 21 results with res_run 0,1,2; done once.
- do_pll_reset=1, locked held 0, LOCK_TIMEOUT=200 -> error=1 and done 200±2 cycles after PRST_OFF; no LOAD write; error clears on next start.
- num_runs=0 -> done pulse within 2 cycles, no m_write/m_read.
- start pulsed again during POLL -> ignored, sequence unaffected; assert m_read and m_write never both high.
- p_reset_1 asserted mid-READ -> all outputs 0 immediately; new start afterwards completes a clean run.

Source files
------------

// File: rtl/pll_meas_pkg.sv
// pll_meas_pkg: slave register map, FSM states and timer sizing for pll_measure_sequencer
package pll_meas_pkg;
  localparam logic [3:0] ADDR_GO       = 4'd0;
  localparam logic [3:0] ADDR_COUNT    = 4'd1;
  localparam logic [3:0] ADDR_CLEAR    = 4'd2;
  localparam logic [3:0] ADDR_RES_BASE = 4'd3;
  localparam logic [3:0] ADDR_LOCKED   = 4'd10;
  localparam logic [3:0] ADDR_PRST     = 4'd11;
  localparam int NUM_RESULTS = 7;
  typedef enum logic [3:0] {
    IDLE, PRST_ON, PRST_OFF, WAIT_LOCK, LOAD, CLEAR, GO, POLL, READ, NEXT
  } state_t;
  // Shared wait timer must hold the largest wait; never narrower than 20 bits.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return $clog2(m + 1) < 20 ? 20 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/pll_seq_timer.sv
// pll_seq_timer: loadable down-counter with zero flag for the sequencer's waits
// Ports: avalon_clock/p_reset_1 (async, active-high); load/load_val reload the count;
// zero is high while the count is 0 (counting stops there).
module pll_seq_timer #(
  parameter int W = 20
) (
  input  logic         avalon_clock,
  input  logic         p_reset_1,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge avalon_clock or posedge p_reset_1) begin
    if (p_reset_1) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/pll_measure_sequencer.sv
// pll_measure_sequencer: Avalon-MM master running repeated PLL clock-measurement runs on one slave
// Ports: avalon_clock, p_reset_1 (async, active-high); start/window_len/num_runs/do_pll_reset from host;
// m_* Avalon-MM master (readdata valid the cycle after m_read); locked from the PLL;
// res_* one strobe per result register; busy/done/error sequence status.
module pll_measure_sequencer
  import pll_meas_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 8,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 1000000,
  parameter int POLL_GAP        = 4
) (
  input  logic        avalon_clock,
  input  logic        p_reset_1,
  input  logic        start,
  input  logic [31:0] window_len,
  input  logic [7:0]  num_runs,
  input  logic        do_pll_reset,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        locked,
  output logic        res_valid,
  output logic [7:0]  res_run,
  output logic [2:0]  res_index,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int TW = timer_width(SETTLE_CYCLES, RST_HOLD_CYCLES, LOCK_TIMEOUT, POLL_GAP);
  state_t        state;
  logic [31:0]   win_l;
  logic [7:0]    runs_l;
  logic          prst_l;
  logic [7:0]    run;
  logic [7:0]    run_nx;
  logic [2:0]    idx;
  logic          ph;
  logic          pend;
  logic [1:0]    lock_sync;
  logic          tm_load;
  logic [TW-1:0] tm_val;
  logic          tm_zero;
  logic          launch_prst;
  assign run_nx = run + 8'd1;
  // Result data is the slave's read response, exposed only while its strobe is up.
  assign res_data = res_valid ? m_readdata : '0;
  assign launch_prst = (state == IDLE && start && num_runs != 8'd0 && do_pll_reset) ||
                       (state == NEXT && run_nx != runs_l && prst_l);
  // Timer is loaded on the edge that enters a waiting state; loading N-1 makes the
  // next strobe land exactly N cycles after the one that started the wait.
  always_comb begin
    tm_val  = launch_prst ? TW'(RST_HOLD_CYCLES - 1) :
              state == LOAD ? TW'(SETTLE_CYCLES - 1) :
              state == PRST_OFF ? TW'(LOCK_TIMEOUT - 1) :
              (state == GO || (state == POLL && pend)) ? TW'(POLL_GAP - 1) : TW'(1);
    tm_load = launch_prst || state inside {LOAD, PRST_OFF, GO} ||
              (state == POLL && tm_zero && (!pend || m_readdata[0]));
  end
  pll_seq_timer #(.W(TW)) u_timer (
    .avalon_clock(avalon_clock),
    .p_reset_1   (p_reset_1),
    .load        (tm_load),
    .load_val    (tm_val),
    .zero        (tm_zero)
  );
  always_ff @(posedge avalon_clock or posedge p_reset_1) begin
    if (p_reset_1) begin
      state       <= IDLE;
      win_l       <= '0;
      runs_l      <= '0;
      prst_l      <= 1'b0;
      run         <= '0;
      idx         <= '0;
      ph          <= 1'b0;
      pend        <= 1'b0;
      lock_sync   <= '0;
      m_address   <= '0;
      m_write     <= 1'b0;
      m_read      <= 1'b0;
      m_writedata <= '0;
      res_valid   <= 1'b0;
      res_run     <= '0;
      res_index   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      lock_sync   <= {lock_sync[0], locked};
      m_address   <= '0;
      m_write     <= 1'b0;
      m_read      <= 1'b0;
      m_writedata <= '0;
      res_valid   <= 1'b0;
      res_run     <= '0;
      res_index   <= '0;
      done        <= 1'b0;
      case (state)
        IDLE: if (start) begin
          win_l  <= window_len;
          runs_l <= num_runs;
          prst_l <= do_pll_reset;
          run    <= '0;
          error  <= 1'b0;
          if (num_runs == 8'd0) done <= 1'b1;
          else begin
            busy        <= 1'b1;
            state       <= do_pll_reset ? PRST_ON : LOAD;
            m_write     <= 1'b1;
            m_address   <= do_pll_reset ? ADDR_PRST : ADDR_COUNT;
            m_writedata <= do_pll_reset ? 32'd1 : window_len;
          end
        end
        PRST_ON: if (tm_zero) begin
          state     <= PRST_OFF;
          m_write   <= 1'b1;
          m_address <= ADDR_PRST;
        end
        PRST_OFF: state <= WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_sync[1]) begin
            state       <= LOAD;
            m_write     <= 1'b1;
            m_address   <= ADDR_COUNT;
            m_writedata <= win_l;
          end else if (tm_zero) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        LOAD: begin
          state       <= CLEAR;
          m_write     <= 1'b1;
          m_address   <= ADDR_CLEAR;
          m_writedata <= 32'd1;
        end
        CLEAR: if (tm_zero) begin
          state       <= GO;
          m_write     <= 1'b1;
          m_address   <= ADDR_GO;
          m_writedata <= 32'd1;
        end
        GO: begin
          state <= POLL;
          pend  <= 1'b0;
        end
        // pend marks an outstanding go read; its data is checked when the 1-cycle wait ends.
        POLL: if (tm_zero) begin
          if (!pend) begin
            m_read    <= 1'b1;
            m_address <= ADDR_GO;
            pend      <= 1'b1;
          end else if (m_readdata[0]) pend <= 1'b0;
          else begin
            state     <= READ;
            m_read    <= 1'b1;
            m_address <= ADDR_RES_BASE;
            idx       <= '0;
            ph        <= 1'b0;
          end
        end
        // ph=0: read strobe on the bus; ph=1: response present, result strobe out.
        READ: begin
          if (!ph) begin
            res_valid <= 1'b1;
            res_index <= idx;
            res_run   <= run;
            ph        <= 1'b1;
          end else if (idx == 3'(NUM_RESULTS - 1)) state <= NEXT;
          else begin
            idx       <= idx + 3'd1;
            m_read    <= 1'b1;
            m_address <= ADDR_RES_BASE + {1'b0, idx} + 4'd1;
            ph        <= 1'b0;
          end
        end
        NEXT: begin
          run <= run_nx;
          if (run_nx == runs_l) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state       <= prst_l ? PRST_ON : LOAD;
            m_write     <= 1'b1;
            m_address   <= prst_l ? ADDR_PRST : ADDR_COUNT;
            m_writedata <= prst_l ? 32'd1 : win_l;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_measure_sequencer.sv
// tb_pll_measure_sequencer: randomized directed bench with a behavioural measurement-slave model
module tb_pll_measure_sequencer;
  localparam int SETTLE = 8, RST_HOLD = 16, LOCK_TO = 200, GAP = 4;
  typedef struct packed {logic [31:0] cyc; logic [3:0] addr; logic [31:0] data;} wr_t;
  logic clk = 1'b0;
  logic p_reset_1, start, do_pll_reset, m_write, m_read, res_valid, busy, done, error;
  logic locked = 1'b0;
  logic [31:0] window_len, m_writedata, res_data;
  logic [31:0] m_readdata = '0;
  logic [7:0] num_runs, res_run;
  logic [3:0] m_address;
  logic [2:0] res_index;
  int n_cmp = 0, n_bad = 0;
  logic mon_clr;
  int cfg_busy, cfg_lock;
  int go_cnt = 0, lock_cnt = -1, run_tb = 0;
  logic [31:0] res_vals [7];
  logic [42:0] exp_res[$];
  bit pv_q[$];
  wr_t wr_q[$];
  logic [3:0] rd_q[$];
  logic [42:0] res_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, both_cnt = 0, min_gap = 0, go_cyc = -1;

  pll_measure_sequencer #(
    .SETTLE_CYCLES(SETTLE), .RST_HOLD_CYCLES(RST_HOLD), .LOCK_TIMEOUT(LOCK_TO), .POLL_GAP(GAP)
  ) dut (
    .avalon_clock(clk), .p_reset_1(p_reset_1), .start(start), .window_len(window_len),
    .num_runs(num_runs), .do_pll_reset(do_pll_reset), .m_address(m_address), .m_write(m_write),
    .m_read(m_read), .m_writedata(m_writedata), .m_readdata(m_readdata), .locked(locked),
    .res_valid(res_valid), .res_run(res_run), .res_index(res_index), .res_data(res_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Measurement slave: go stays high cfg_busy cycles after a go write, fresh random
  // results per run, PLL locks cfg_lock cycles after pll_reset is released (never if < 0).
  always @(posedge clk) begin
    if (mon_clr) begin
      exp_res.delete();
      pv_q.delete();
      run_tb = 0;
    end
    m_readdata <= '0;
    if (go_cnt > 0) go_cnt <= go_cnt - 1;
    if (lock_cnt > 0) lock_cnt <= lock_cnt - 1;
    else if (lock_cnt == 0) begin
      locked <= 1'b1;
      lock_cnt <= -1;
    end
    if (m_write && m_address == 4'd0 && m_writedata[0]) begin
      go_cnt <= cfg_busy;
      for (int i = 0; i < 7; i++) begin
        res_vals[i] = $urandom;
        exp_res.push_back({run_tb[7:0], 3'(i), res_vals[i]});
      end
      run_tb++;
    end
    if (m_write && m_address == 4'd11) begin
      locked <= 1'b0;
      lock_cnt <= m_writedata[0] ? -1 : cfg_lock;
    end
    if (m_read && m_address == 4'd0) begin
      m_readdata <= {31'd0, go_cnt != 0};
      pv_q.push_back(go_cnt != 0);
    end else if (m_read && m_address >= 4'd3 && m_address <= 4'd9)
      m_readdata <= res_vals[int'(m_address) - 3];
  end

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      wr_q.delete();
      rd_q.delete();
      res_q.delete();
      min_gap = 1 << 30;
      go_cyc = -1;
    end
    if (m_write) begin
      wr_q.push_back({32'(cyc), m_address, m_writedata});
      if (m_address == 4'd0) go_cyc = cyc;
    end
    if (m_read) begin
      rd_q.push_back(m_address);
      if (m_address == 4'd0 && go_cyc >= 0) begin
        if (cyc - go_cyc < min_gap) min_gap = cyc - go_cyc;
        go_cyc = -1;
      end
    end
    if (m_read && m_write) both_cnt++;
    if (res_valid) res_q.push_back({res_run, res_index, res_data});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic run_seq(input int nr, input logic dpr, input logic [31:0] win, input int blen,
                         input int lk, input logic poke);
    int d0, k, j, n, polls, zeros;
    cfg_busy = blen;
    cfg_lock = lk;
    clr();
    d0 = done_cnt;
    num_runs = 8'(nr);
    window_len = win;
    do_pll_reset = dpr;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clr", error, 0);
    chk("busy_on", busy, 1);
    window_len = $urandom;
    num_runs = 8'($urandom_range(255, 1));
    do_pll_reset = ~dpr;
    if (poke) begin
      for (int i = 0; i < 2000 && pv_q.size() == 0; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_poke", busy, 1);
    end
    for (int i = 0; i < 20000 && done_cnt == d0; i++) tick();
    repeat (4) tick();
    chk("done_once", done_cnt - d0, 1);
    chk("busy_end", busy, 0);
    chk("error_end", error, 0);
    k = 0;
    for (int r = 0; r < nr; r++) begin
      if (dpr) begin
        chk("w_prst_on", {wr_q[k].addr, wr_q[k].data}, {4'd11, 32'd1});
        chk("w_prst_off", {wr_q[k+1].addr, wr_q[k+1].data}, {4'd11, 32'd0});
        chk("prst_hold", wr_q[k+1].cyc - wr_q[k].cyc, RST_HOLD);
        k += 2;
      end
      chk("w_load", {wr_q[k].addr, wr_q[k].data}, {4'd1, win});
      chk("w_clear", wr_q[k+1].addr, 4'd2);
      chk("w_go", {wr_q[k+2].addr, wr_q[k+2].data}, {4'd0, 32'd1});
      chk("settle", wr_q[k+2].cyc - wr_q[k+1].cyc, SETTLE);
      k += 3;
    end
    chk("n_writes", wr_q.size(), k);
    j = 0;
    polls = 0;
    for (int r = 0; r < nr; r++) begin
      n = 0;
      while (j < rd_q.size() && rd_q[j] == 4'd0) begin
        n++;
        j++;
      end
      chk("polls_present", n > 0, 1);
      polls += n;
      for (int i = 0; i < 7; i++) begin
        chk("rd_addr", rd_q[j], 3 + i);
        j++;
      end
    end
    chk("n_reads", rd_q.size(), j);
    zeros = 0;
    foreach (pv_q[i]) if (!pv_q[i]) zeros++;
    chk("poll_zero_per_run", zeros, nr);
    chk("poll_total", pv_q.size(), polls);
    if (blen == 0) chk("single_poll", polls, nr);
    chk("poll_gap", min_gap >= GAP, 1);
    chk("n_results", res_q.size(), 7 * nr);
    for (int i = 0; i < 7 * nr; i++) chk("result", res_q[i], exp_res[i]);
    chk("strobe_excl", both_cnt, 0);
  endtask

  initial begin
    int d0, dl, st;
    start = 1'b0;
    window_len = '0;
    num_runs = '0;
    do_pll_reset = 1'b0;
    mon_clr = 1'b0;
    cfg_busy = 0;
    cfg_lock = 50;
    p_reset_1 = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", |{m_address, m_write, m_read, m_writedata, res_valid, res_run,
                           res_index, res_data, busy, done, error}, 0);
    p_reset_1 = 1'b0;
    tick();
    run_seq(1, 1'b0, 32'd100, 120, 50, 1'b0);
    run_seq(3, 1'b1, $urandom, int'($urandom_range(40, 1)), 50, 1'b0);
    // Lock never arrives: timeout must abandon the remaining runs.
    cfg_lock = -1;
    clr();
    d0 = done_cnt;
    num_runs = 8'd2;
    do_pll_reset = 1'b1;
    window_len = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
    repeat (3) tick();
    chk("to_done", done_cnt - d0, 1);
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_writes", wr_q.size(), 2);
    chk("to_prst_off", {wr_q[1].addr, wr_q[1].data}, {4'd11, 32'd0});
    dl = done_cyc - int'(wr_q[1].cyc);
    chk("to_latency", dl >= LOCK_TO - 2 && dl <= LOCK_TO + 2, 1);
    chk("to_reads", rd_q.size(), 0);
    run_seq(2, 1'b0, $urandom, 60, 50, 1'b0);
    // Zero runs: immediate done, no bus traffic.
    clr();
    d0 = done_cnt;
    num_runs = 8'd0;
    st = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("zero_done", done_cnt - d0, 1);
    chk("zero_latency", done_cyc - st >= 1 && done_cyc - st <= 2, 1);
    chk("zero_traffic", wr_q.size() + rd_q.size(), 0);
    run_seq(2, 1'b1, $urandom, 80, 30, 1'b1);
    run_seq(2, 1'b0, 32'd1, 0, 50, 1'b0);
    // Reset in the middle of the result reads.
    cfg_busy = 30;
    clr();
    num_runs = 8'd1;
    do_pll_reset = 1'b0;
    window_len = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && res_q.size() < 2; i++) tick();
    chk("in_read", res_q.size() >= 2, 1);
    p_reset_1 = 1'b1;
    #1;
    chk("mid_reset_outputs", |{m_address, m_write, m_read, m_writedata, res_valid, res_run,
                               res_index, res_data, busy, done, error}, 0);
    tick();
    p_reset_1 = 1'b0;
    tick();
    run_seq(1, 1'b0, $urandom, 20, 50, 1'b0);
    for (int t = 0; t < 3; t++)
      run_seq(int'($urandom_range(3, 1)), 1'($urandom_range(1, 0)), $urandom,
              int'($urandom_range(50, 0)), int'($urandom_range(100, 5)), 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
